// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and constants for the two-input round-robin
// packet arbiter and its 1-bit select multiplexer.
//   arb_state_e : arbiter FSM state (IDLE, GRANT_A, GRANT_B)
//   SEL_A/SEL_B : select encoding shared by arbiter, mux and priority pointer
package rr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } arb_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_2x1.sv
// mux_2x1: 1-bit two-input multiplexer.
//   a_i   : input selected when sel_i == SEL_A
//   b_i   : input selected when sel_i == SEL_B
//   sel_i : select
//   y_o   : selected bit
module mux_2x1
  import rr_arb_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  output logic y_o
);

  assign y_o = (sel_i == SEL_B) ? b_i : a_i;

endmodule

// File: rtl/rr_arb_2x1.sv
// rr_arb_2x1: round-robin arbiter merging two valid/ready packet streams
// (A, B) into one registered output stream. A grant is held for a whole
// packet; ownership alternates between A and B under contention.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   a_valid/a_data/a_last/a_ready : requester A beat handshake
//   b_valid/b_data/b_last/b_ready : requester B beat handshake
//   out_valid/out_data/out_last   : registered output beat
//   out_ready                     : downstream accept
//   sel                           : registered mux select (0 = A, 1 = B)
//   busy                          : a grant is currently held
module rr_arb_2x1
  import rr_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              b_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              prio_q, prio_d;
  logic              sel_q, sel_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic              slot_free;
  logic              gnt_sel;
  logic              accept;
  logic [DATA_W:0]   a_bus, b_bus, mux_bus;
  logic [DATA_W-1:0] mux_data;
  logic              mux_last;

  // The output slot can take a new beat if it is empty or being drained.
  assign slot_free = !out_valid_q || out_ready;
  assign a_ready   = (state_q == GRANT_A) && slot_free;
  assign b_ready   = (state_q == GRANT_B) && slot_free;
  assign accept    = (a_valid && a_ready) || (b_valid && b_ready);

  // The mux follows the current grant combinationally, so the beat being
  // accepted this cycle is the one presented to the output register.
  assign gnt_sel = (state_q == GRANT_B) ? SEL_B : SEL_A;

  // Bit DATA_W carries the last flag alongside the payload.
  assign a_bus = {a_last, a_data};
  assign b_bus = {b_last, b_data};

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W + 1; gi++) begin : g_mux
      mux_2x1 u_mux (
        .a_i   (a_bus[gi]),
        .b_i   (b_bus[gi]),
        .sel_i (gnt_sel),
        .y_o   (mux_bus[gi])
      );
    end
  endgenerate

  assign mux_data = mux_bus[DATA_W-1:0];
  assign mux_last = mux_bus[DATA_W];

  // Next-state, priority pointer and select.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (a_valid && b_valid) begin
          state_d = (prio_q == SEL_B) ? GRANT_B : GRANT_A;
        end else if (a_valid) begin
          state_d = GRANT_A;
        end else if (b_valid) begin
          state_d = GRANT_B;
        end
      end
      GRANT_A: begin
        if (accept && mux_last) begin
          state_d = IDLE;
          prio_d  = SEL_B;
        end
      end
      GRANT_B: begin
        if (accept && mux_last) begin
          state_d = IDLE;
          prio_d  = SEL_A;
        end
      end
      default: state_d = IDLE;
    endcase
    // sel is registered from the next state so it lines up with the grant
    // state; across an IDLE pass it keeps the last owner.
    if (state_d == GRANT_A) begin
      sel_d = SEL_A;
    end else if (state_d == GRANT_B) begin
      sel_d = SEL_B;
    end
  end

  // Output register: load on accept, drain when taken, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_last_d  = mux_last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= SEL_A;
      sel_q       <= SEL_A;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      sel_q       <= sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rr_arb_2x1.sv
module tb_rr_arb_2x1;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              a_valid, b_valid;
  logic [DATA_W-1:0] a_data, b_data;
  logic              a_last, b_last;
  logic              a_ready, b_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              sel;
  logic              busy;

  int checks = 0;
  int errors = 0;

  rr_arb_2x1 #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_last    (a_last),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_last    (b_last),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard of beats expected on the output, in order.
  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              src;
  } beat_t;
  beat_t sb[$];

  // One table row: inputs for one cycle and expected outputs in that cycle.
  typedef struct {
    logic              av;
    logic [DATA_W-1:0] ad;
    logic              al;
    logic              bv;
    logic [DATA_W-1:0] bd;
    logic              bl;
    logic              xa;
    logic              xb;
    logic              xov;
    logic [DATA_W-1:0] xod;
    logic              xol;
    logic              xsel;
    logic              xbusy;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vec[NVEC];

  function automatic vec_t mk(input logic av, input logic [7:0] ad, input logic al,
                              input logic bv, input logic [7:0] bd, input logic bl,
                              input logic xa, input logic xb, input logic xov,
                              input logic [7:0] xod, input logic xol,
                              input logic xsel, input logic xbusy);
    vec_t v;
    v.av = av; v.ad = ad; v.al = al;
    v.bv = bv; v.bd = bd; v.bl = bl;
    v.xa = xa; v.xb = xb; v.xov = xov; v.xod = xod; v.xol = xol;
    v.xsel = xsel; v.xbusy = xbusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [7:0] ad, input logic al,
                       input logic bv, input logic [7:0] bd, input logic bl,
                       input logic orr);
    @(negedge clk);
    a_valid = av; a_data = ad; a_last = al;
    b_valid = bv; b_data = bd; b_last = bl;
    out_ready = orr;
    #1;
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l, input logic s);
    beat_t b;
    b.data = d; b.last = l; b.src = s;
    sb.push_back(b);
  endtask

  // Output monitor: a transfer happens at the next rising edge whenever
  // out_valid && out_ready is seen mid-cycle.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL out_beat unexpected actual=%0h/%0d required=none", out_data, out_last);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if (out_data !== e.data || out_last !== e.last || sel !== e.src) begin
          errors++;
          $display("FAIL out_beat actual=%0h/%0d/%0d required=%0h/%0d/%0d",
                   out_data, out_last, sel, e.data, e.last, e.src);
        end else begin
          $display("BEAT data=%02h last=%0d src=%0d", out_data, out_last, sel);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Contention: A and B each send two 2-beat packets, then A alone.
    vec[0]  = mk(1, 8'hA0, 0, 1, 8'hB0, 0,  0, 0, 0, 8'h00, 0, 0, 0);
    vec[1]  = mk(1, 8'hA0, 0, 1, 8'hB0, 0,  1, 0, 0, 8'h00, 0, 0, 1);
    vec[2]  = mk(1, 8'hA1, 1, 1, 8'hB0, 0,  1, 0, 1, 8'hA0, 0, 0, 1);
    vec[3]  = mk(1, 8'hA2, 0, 1, 8'hB0, 0,  0, 0, 1, 8'hA1, 1, 0, 0);
    vec[4]  = mk(1, 8'hA2, 0, 1, 8'hB0, 0,  0, 1, 0, 8'h00, 0, 1, 1);
    vec[5]  = mk(1, 8'hA2, 0, 1, 8'hB1, 1,  0, 1, 1, 8'hB0, 0, 1, 1);
    vec[6]  = mk(1, 8'hA2, 0, 1, 8'hB2, 0,  0, 0, 1, 8'hB1, 1, 1, 0);
    vec[7]  = mk(1, 8'hA2, 0, 1, 8'hB2, 0,  1, 0, 0, 8'h00, 0, 0, 1);
    vec[8]  = mk(1, 8'hA3, 1, 1, 8'hB2, 0,  1, 0, 1, 8'hA2, 0, 0, 1);
    vec[9]  = mk(0, 8'h00, 0, 1, 8'hB2, 0,  0, 0, 1, 8'hA3, 1, 0, 0);
    vec[10] = mk(0, 8'h00, 0, 1, 8'hB2, 0,  0, 1, 0, 8'h00, 0, 1, 1);
    vec[11] = mk(0, 8'h00, 0, 1, 8'hB3, 1,  0, 1, 1, 8'hB2, 0, 1, 1);
    vec[12] = mk(0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 1, 8'hB3, 1, 1, 0);
    // A alone: 3-beat packet 11, 22, 33.
    vec[13] = mk(1, 8'h11, 0, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0, 1, 0);
    vec[14] = mk(1, 8'h11, 0, 0, 8'h00, 0,  1, 0, 0, 8'h00, 0, 0, 1);
    vec[15] = mk(1, 8'h22, 0, 0, 8'h00, 0,  1, 0, 1, 8'h11, 0, 0, 1);
    vec[16] = mk(1, 8'h33, 1, 0, 8'h00, 0,  1, 0, 1, 8'h22, 0, 0, 1);
    vec[17] = mk(0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 1, 8'h33, 1, 0, 0);
    vec[18] = mk(0, 8'h00, 0, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0, 0, 0);

    // Reset with both requesters valid.
    rst_n = 1'b0;
    a_valid = 1'b1; a_data = 8'h5A; a_last = 1'b0;
    b_valid = 1'b1; b_data = 8'hC3; b_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {a_ready, b_ready, out_valid, out_data, out_last, sel, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;

    // Table-driven contention and single-requester run.
    for (int i = 0; i < NVEC; i++) begin
      logic [DATA_W+5:0] act, exp;
      drive(vec[i].av, vec[i].ad, vec[i].al, vec[i].bv, vec[i].bd, vec[i].bl, 1'b1);
      act = {a_ready, b_ready, out_valid, sel, busy,
             vec[i].xov ? {out_data, out_last} : {(DATA_W+1){1'b0}}};
      exp = {vec[i].xa, vec[i].xb, vec[i].xov, vec[i].xsel, vec[i].xbusy,
             vec[i].xov ? {vec[i].xod, vec[i].xol} : {(DATA_W+1){1'b0}}};
      chk($sformatf("vec%0d", i), 32'(act), 32'(exp));
      if (vec[i].av && vec[i].xa) expect_beat(vec[i].ad, vec[i].al, 1'b0);
      if (vec[i].bv && vec[i].xb) expect_beat(vec[i].bd, vec[i].bl, 1'b1);
    end

    // Backpressure: out_ready low for 4 cycles mid-packet.
    drive(1, 8'hC1, 0, 0, 8'h00, 0, 1);
    chk("bp_idle_ready", a_ready, 0);
    drive(1, 8'hC1, 0, 0, 8'h00, 0, 1);
    chk("bp_ready_first", a_ready, 1);
    expect_beat(8'hC1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 8'hC2, 0, 0, 8'h00, 0, 0);
      chk($sformatf("bp_stall_ready%0d", k), a_ready, 0);
      chk($sformatf("bp_stall_out%0d", k), {out_valid, out_data, out_last}, {1'b1, 8'hC1, 1'b0});
    end
    drive(1, 8'hC2, 0, 0, 8'h00, 0, 1);
    chk("bp_release_ready", a_ready, 1);
    expect_beat(8'hC2, 0, 0);
    drive(1, 8'hC3, 1, 0, 8'h00, 0, 1);
    chk("bp_last_ready", a_ready, 1);
    expect_beat(8'hC3, 1, 0);
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);

    // Lock: B granted, b_valid drops for 3 cycles while A is waiting.
    drive(1, 8'hE0, 0, 1, 8'hD0, 0, 1);
    chk("lock_idle_busy", busy, 0);
    drive(1, 8'hE0, 0, 1, 8'hD0, 0, 1);
    chk("lock_b_granted", {a_ready, b_ready, sel}, 3'b011);
    expect_beat(8'hD0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      drive(1, 8'hE0, 0, 0, 8'h00, 0, 1);
      chk($sformatf("lock_hold%0d", k), {a_ready, sel, busy}, 3'b011);
    end
    drive(1, 8'hE0, 0, 1, 8'hD1, 1, 1);
    chk("lock_b_last", {a_ready, b_ready}, 2'b01);
    expect_beat(8'hD1, 1, 1);
    drive(1, 8'hE0, 0, 0, 8'h00, 0, 1);
    chk("lock_idle_pass", {a_ready, busy}, 2'b00);
    drive(1, 8'hE0, 0, 0, 8'h00, 0, 1);
    chk("lock_a_served", {a_ready, sel}, 2'b10);
    expect_beat(8'hE0, 0, 0);
    drive(1, 8'hE1, 1, 0, 8'h00, 0, 1);
    chk("lock_a_last", a_ready, 1);
    expect_beat(8'hE1, 1, 0);
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);

    // Reset mid-packet: the beat in the output register is abandoned.
    drive(1, 8'hF0, 0, 0, 8'h00, 0, 1);
    drive(1, 8'hF0, 0, 0, 8'h00, 0, 1);
    chk("rst_mid_accept", a_ready, 1);
    drive(1, 8'hF1, 0, 0, 8'h00, 0, 0);
    chk("rst_mid_held", {out_valid, out_data}, {1'b1, 8'hF0});
    chk("rst_mid_sb_drained", sb.size(), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {a_ready, b_ready, out_valid, out_data, out_last, sel, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;

    // After release prio is back on A; B then sends a single-beat packet.
    drive(1, 8'h61, 0, 1, 8'h71, 1, 1);
    drive(1, 8'h61, 0, 1, 8'h71, 1, 1);
    chk("post_rst_grant_a", {a_ready, b_ready, sel}, 3'b100);
    expect_beat(8'h61, 0, 0);
    drive(1, 8'h62, 1, 1, 8'h71, 1, 1);
    chk("post_rst_a_last", a_ready, 1);
    expect_beat(8'h62, 1, 0);
    drive(0, 8'h00, 0, 1, 8'h71, 1, 1);
    chk("post_rst_idle", busy, 0);
    drive(0, 8'h00, 0, 1, 8'h71, 1, 1);
    chk("single_beat_b", {b_ready, sel}, 2'b11);
    expect_beat(8'h71, 1, 1);
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    chk("single_beat_done", busy, 0);
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
